sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO. It is the next generation of the team's byte FIFO used to stage UDP packet bytes between parser and transmit logic.
Adds generic width and depth, a first-word-fall-through (FWFT) mode, occupancy count, programmable almost-full/almost-empty flags, and overflow/underflow error pulses.
Instantiated wherever packet bytes or header words are buffered between producer and consumer stages on one clock.

---
 rtl/sync_fifo_param.sv | 108 ++++++++++
 tb/tb_sync_fifo_param.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through read,
// occupancy count, threshold flags and overflow/underflow error pulses.
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter bit FWFT     = 1'b0,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                    clk,
  input  logic                    srst,
  input  logic [DATA_W-1:0]       din,
  input  logic                    wr_en,
  input  logic                    rd_en,
  output logic [DATA_W-1:0]       dout,
  output logic                    valid,
  output logic                    empty,
  output logic                    full,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  data_count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] CNT_AE   = CW'(AE_LEVEL);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt_nxt;
  logic              wr_acc;
  logic              rd_acc;
  logic              head_mem;
  logic              head_din;
  logic              mem_wr;
  logic              mem_rd;
  logic              rd_valid;

  // In FWFT mode the count includes the head word held in dout,
  // so memory holds data_count-1 words while the head is loaded.
  always_comb begin
    wr_acc   = wr_en && !full;
    rd_acc   = rd_en && !empty;
    head_mem = 1'b0;
    head_din = 1'b0;
    if (FWFT) begin
      head_mem = rd_acc && (data_count > CNT_ONE);
      head_din = wr_acc &&
                 (empty || (rd_acc && data_count == CNT_ONE));
    end
    mem_rd  = FWFT ? head_mem : rd_acc;
    mem_wr  = wr_acc && !head_din;
    cnt_nxt = data_count;
    case ({wr_acc, rd_acc})
      2'b10:   cnt_nxt = data_count + CNT_ONE;
      2'b01:   cnt_nxt = data_count - CNT_ONE;
      default: cnt_nxt = data_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_wr)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      data_count   <= '0;
      dout         <= '0;
      rd_valid     <= 1'b0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (mem_wr)
        wr_ptr <= wr_ptr + AW'(1);
      if (mem_rd)
        rd_ptr <= rd_ptr + AW'(1);
      data_count   <= cnt_nxt;
      empty        <= (cnt_nxt == '0);
      full         <= (cnt_nxt == CNT_FULL);
      almost_full  <= (cnt_nxt >= CNT_AF);
      almost_empty <= (cnt_nxt <= CNT_AE);
      overflow     <= wr_en && full;
      underflow    <= rd_en && empty;
      rd_valid     <= rd_acc;
      if (mem_rd)
        dout <= mem[rd_ptr];
      else if (head_din)
        dout <= din;
    end
  end

  assign valid = FWFT ? !empty : rd_valid;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: standard, FWFT and custom-threshold instances
// share one stimulus stream and are checked against a queue model.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       srst;
  logic [7:0] din;
  logic       wr_en;
  logic       rd_en;

  logic [7:0] s_dout, f_dout, t_dout;
  logic       s_valid, f_valid, t_valid;
  logic       s_empty, f_empty, t_empty;
  logic       s_full, f_full, t_full;
  logic       s_af, f_af, t_af;
  logic       s_ae, f_ae, t_ae;
  logic [3:0] s_cnt, f_cnt, t_cnt;
  logic       s_ov, f_ov, t_ov;
  logic       s_un, f_un, t_un;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_W(8), .DEPTH(8), .FWFT(1'b0)) u_std (
    .clk(clk), .srst(srst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(s_dout), .valid(s_valid), .empty(s_empty), .full(s_full),
    .almost_full(s_af), .almost_empty(s_ae), .data_count(s_cnt),
    .overflow(s_ov), .underflow(s_un)
  );

  sync_fifo_param #(.DATA_W(8), .DEPTH(8), .FWFT(1'b1)) u_fw (
    .clk(clk), .srst(srst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(f_dout), .valid(f_valid), .empty(f_empty), .full(f_full),
    .almost_full(f_af), .almost_empty(f_ae), .data_count(f_cnt),
    .overflow(f_ov), .underflow(f_un)
  );

  sync_fifo_param #(.DATA_W(8), .DEPTH(8), .FWFT(1'b0),
                    .AF_LEVEL(6), .AE_LEVEL(2)) u_thr (
    .clk(clk), .srst(srst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(t_dout), .valid(t_valid), .empty(t_empty), .full(t_full),
    .almost_full(t_af), .almost_empty(t_ae), .data_count(t_cnt),
    .overflow(t_ov), .underflow(t_un)
  );

  // Queue model: contents are identical for all three instances,
  // only the read-side presentation differs between modes.
  logic [7:0] q [$];
  logic [7:0] m_sd;
  logic       m_sv;
  logic [7:0] m_fd;
  logic       m_ov;
  logic       m_un;
  bit         live = 1'b0;

  always @(posedge clk) begin
    if (srst) begin
      q.delete();
      m_sd = 8'd0;
      m_sv = 1'b0;
      m_fd = 8'd0;
      m_ov = 1'b0;
      m_un = 1'b0;
      live = 1'b1;
    end else begin
      automatic int  n  = q.size();
      automatic bit  wa = wr_en && (n < 8);
      automatic bit  ra = rd_en && (n > 0);
      m_ov = wr_en && (n == 8);
      m_un = rd_en && (n == 0);
      m_sv = ra;
      if (ra)
        m_sd = q.pop_front();
      if (wa)
        q.push_back(din);
      if (q.size() > 0)
        m_fd = q[0];
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d, expected %0d @%0t", name, act, exp, $time);
  endtask

  task automatic cmp(input string t, input logic [7:0] d, input logic v,
                     input logic e, input logic f, input logic af,
                     input logic ae, input logic [3:0] c, input logic o,
                     input logic u, input bit fw, input int afl,
                     input int ael);
    automatic int n = q.size();
    chk({t, " count"}, c, n);
    chk({t, " empty"}, e, n == 0);
    chk({t, " full"}, f, n == 8);
    chk({t, " almost_full"}, af, n >= afl);
    chk({t, " almost_empty"}, ae, n <= ael);
    chk({t, " overflow"}, o, m_ov);
    chk({t, " underflow"}, u, m_un);
    if (fw) begin
      chk({t, " valid"}, v, n > 0);
      chk({t, " dout"}, d, m_fd);
    end else begin
      chk({t, " valid"}, v, m_sv);
      chk({t, " dout"}, d, m_sd);
    end
  endtask

  always @(negedge clk) begin
    if (live) begin
      cmp("std", s_dout, s_valid, s_empty, s_full, s_af, s_ae, s_cnt,
          s_ov, s_un, 1'b0, 7, 1);
      cmp("fwft", f_dout, f_valid, f_empty, f_full, f_af, f_ae, f_cnt,
          f_ov, f_un, 1'b1, 7, 1);
      cmp("thr", t_dout, t_valid, t_empty, t_full, t_af, t_ae, t_cnt,
          t_ov, t_un, 1'b0, 6, 2);
    end
  end

  task automatic tick(input logic w, input logic r, input logic [7:0] d,
                      input logic rst);
    wr_en = w;
    rd_en = r;
    din   = d;
    srst  = rst;
    @(negedge clk);
  endtask

  logic [7:0] v1 [0:9];

  initial begin
    v1 = '{8'd196, 8'd111, 8'd147, 8'd244, 8'd99,
           8'd2, 8'd37, 8'd150, 8'd244, 8'd141};
    srst  = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = 8'd0;
    @(negedge clk);

    tick(1'b0, 1'b0, 8'd0, 1'b1);
    chk("rst count", s_cnt, 0);
    chk("rst empty", s_empty, 1);
    chk("rst ae", s_ae, 1);
    chk("rst fw empty", f_empty, 1);

    // Pop right after reset
    tick(1'b0, 1'b1, 8'd0, 1'b0);
    chk("uf pulse", s_un, 1);
    chk("uf dout", s_dout, 0);
    chk("uf valid", s_valid, 0);
    chk("uf count", s_cnt, 0);
    tick(1'b0, 1'b0, 8'd0, 1'b0);
    chk("uf end", s_un, 0);

    // Fill past full, with threshold points on the custom instance
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b0, v1[i], 1'b0);
      if (i == 1) chk("thr ae@2", t_ae, 1);
      if (i == 2) chk("thr ae@3", t_ae, 0);
      if (i == 4) chk("thr af@5", t_af, 0);
      if (i == 5) chk("thr af@6", t_af, 1);
      if (i == 7) chk("full@8", s_full, 1);
      if (i >= 8) chk("ovf pulse", s_ov, 1);
    end
    chk("count 8", s_cnt, 8);
    tick(1'b0, 1'b0, 8'd0, 1'b0);
    chk("ovf end", s_ov, 0);

    // Drain
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b1, 8'd0, 1'b0);
      chk("pop valid", s_valid, 1);
      chk("pop data", s_dout, v1[i]);
      if (i == 1) chk("thr af@6 drain", t_af, 1);
      if (i == 2) chk("thr af@5 drain", t_af, 0);
      if (i == 4) chk("thr ae@3 drain", t_ae, 0);
      if (i == 5) chk("thr ae@2 drain", t_ae, 1);
    end
    chk("drained empty", s_empty, 1);
    tick(1'b0, 1'b0, 8'd0, 1'b0);
    chk("idle valid", s_valid, 0);

    // FWFT single word
    tick(1'b1, 1'b0, 8'hA5, 1'b0);
    chk("fw head", f_dout, 8'hA5);
    chk("fw not empty", f_empty, 0);
    tick(1'b0, 1'b1, 8'd0, 1'b0);
    chk("fw empty after pop", f_empty, 1);

    // Steady state at 7 words across the pointer wrap
    for (int i = 0; i < 7; i++)
      tick(1'b1, 1'b0, 8'(i), 1'b0);
    for (int j = 0; j < 20; j++) begin
      tick(1'b1, 1'b1, 8'(j + 7), 1'b0);
      chk("steady count", s_cnt, 7);
      chk("steady std data", s_dout, j);
      chk("steady fw head", f_dout, j + 1);
    end

    // Reset while holding 5 words, with a write requested
    tick(1'b0, 1'b1, 8'd0, 1'b0);
    tick(1'b0, 1'b1, 8'd0, 1'b0);
    chk("count 5", s_cnt, 5);
    tick(1'b1, 1'b0, 8'hEE, 1'b1);
    chk("srst count", s_cnt, 0);
    chk("srst empty", s_empty, 1);
    chk("srst valid", s_valid, 0);
    chk("srst dout", s_dout, 0);
    chk("srst fw dout", f_dout, 0);
    chk("srst fw count", f_cnt, 0);
    tick(1'b0, 1'b0, 8'd0, 1'b0);
    chk("post srst count", s_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
